// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array skew feeder: FSM encoding,
// drain-length computation and lane slicing helper.
package sa_pkg;

  // Feeder operating states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } sa_state_t;

  // Cycles of zero injection needed to push the last wavefront through
  // an hpe x vpe array after its final operand enters the skew chains.
  function automatic int drain_cycles(input int hpe, input int vpe);
    return hpe + vpe - 1;
  endfunction

  // Low bit index of a lane inside a packed multi-lane bus.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/sa_skew_lane.sv
// Single-lane operand delay chain. DEPTH registers in series, shifting
// every cycle; the output is the last register so lane latency is DEPTH.
module sa_skew_lane #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] chain_r [DEPTH];

  // Shift chain: clears on reset, otherwise advances one stage per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        chain_r[k] <= '0;
      end
    end else begin
      chain_r[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        chain_r[k] <= chain_r[k-1];
      end
    end
  end

  assign dout = chain_r[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// Operand feeder for the systolic array: accepts one A row and one B
// column per beat, applies the diagonal skew (lane i delayed i cycles),
// and after the last beat injects zeros until the wavefront has drained.
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int HPE   = 8,
  parameter int VPE   = 8,
  parameter int CNTW  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH*HPE-1:0]  A_IN,
  input  logic [WIDTH*VPE-1:0]  B_IN,
  input  logic                  IN_VALID,
  input  logic                  IN_LAST,
  output logic                  IN_READY,
  output logic [WIDTH*HPE-1:0]  AA,
  output logic [WIDTH*VPE-1:0]  BB,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [CNTW-1:0]       BEAT_CNT
);

  // Drain counter sized to hold HPE+VPE-1
  localparam int DW = $clog2(HPE + VPE) + 1;
  localparam logic [DW-1:0] DRAIN = DW'(drain_cycles(HPE, VPE));

  sa_state_t        state_r;
  sa_state_t        state_next;
  logic [DW-1:0]    drain_r;
  logic [DW-1:0]    drain_next;
  logic [CNTW-1:0]  beat_r;
  logic [CNTW-1:0]  beat_next;
  logic             busy_r;
  logic             done_r;
  logic             ready_s;
  logic             accept_s;
  logic [WIDTH*HPE-1:0] a_feed_s;
  logic [WIDTH*VPE-1:0] b_feed_s;

  // Ready is withheld during flush and while reset is asserted
  assign ready_s  = ~RST & (state_r != ST_FLUSH);
  assign accept_s = IN_VALID & ready_s;

  // Non-accepted cycles push zero bubbles into the chains
  assign a_feed_s = accept_s ? A_IN : '0;
  assign b_feed_s = accept_s ? B_IN : '0;

  // Triangular skew: lane i gets i+1 stages on each side
  for (genvar i = 0; i < HPE; i++) begin : g_a_lane
    localparam int LO = lane_lo(i, WIDTH);
    sa_skew_lane #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_lane (
      .clk  (CLK),
      .rst  (RST),
      .din  (a_feed_s[LO +: WIDTH]),
      .dout (AA[LO +: WIDTH])
    );
  end

  for (genvar j = 0; j < VPE; j++) begin : g_b_lane
    localparam int LO = lane_lo(j, WIDTH);
    sa_skew_lane #(.WIDTH(WIDTH), .DEPTH(j + 1)) u_lane (
      .clk  (CLK),
      .rst  (RST),
      .din  (b_feed_s[LO +: WIDTH]),
      .dout (BB[LO +: WIDTH])
    );
  end

  // Next-state, drain counter and beat counter logic
  always_comb begin
    state_next = state_r;
    drain_next = drain_r;
    beat_next  = beat_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          beat_next = CNTW'(1);
          if (IN_LAST) begin
            state_next = ST_FLUSH;
            drain_next = DRAIN;
          end else begin
            state_next = ST_STREAM;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (accept_s) begin
          if (beat_r == {CNTW{1'b1}}) begin
            beat_next = beat_r;
          end else begin
            beat_next = beat_r + CNTW'(1);
          end
          if (IN_LAST) begin
            state_next = ST_FLUSH;
            drain_next = DRAIN;
          end else begin
            state_next = ST_STREAM;
          end
        end else begin
          state_next = ST_STREAM;
        end
      end
      ST_FLUSH: begin
        if (drain_r == DW'(1)) begin
          state_next = ST_IDLE;
          drain_next = '0;
        end else begin
          state_next = ST_FLUSH;
          drain_next = drain_r - DW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        drain_next = '0;
      end
    endcase
  end

  // State, counters and registered status flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      drain_r <= '0;
      beat_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      drain_r <= drain_next;
      beat_r  <= beat_next;
      busy_r  <= (state_next != ST_IDLE);
      // DONE coincides with the final flush cycle (counter at 1)
      done_r  <= (state_next == ST_FLUSH) && (drain_next == DW'(1));
    end
  end

  assign IN_READY = ready_s;
  assign BUSY     = busy_r;
  assign DONE     = done_r;
  assign BEAT_CNT = beat_r;

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Self-checking bench for sa_skew_feeder: directed steps plus random
// bursts, checked against a history-based model of the skew and flush.
module tb_sa_skew_feeder;

  localparam int W      = 32;
  localparam int H      = 8;
  localparam int V      = 8;
  localparam int CW     = 3;
  localparam int DRAIN  = H + V - 1;
  localparam int MAXB   = (1 << CW) - 1;
  localparam int NE     = 1024;
  localparam int VW     = 256;

  logic             CLK;
  logic             RST;
  logic [W*H-1:0]   A_IN;
  logic [W*V-1:0]   B_IN;
  logic             IN_VALID;
  logic             IN_LAST;
  logic             IN_READY;
  logic [W*H-1:0]   AA;
  logic [W*V-1:0]   BB;
  logic             BUSY;
  logic             DONE;
  logic [CW-1:0]    BEAT_CNT;

  sa_skew_feeder #(.WIDTH(W), .HPE(H), .VPE(V), .CNTW(CW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .A_IN     (A_IN),
    .B_IN     (B_IN),
    .IN_VALID (IN_VALID),
    .IN_LAST  (IN_LAST),
    .IN_READY (IN_READY),
    .AA       (AA),
    .BB       (BB),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .BEAT_CNT (BEAT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: words fed into the chains at each edge, plus burst bookkeeping
  logic [W*H-1:0] fed_a [NE];
  logic [W*V-1:0] fed_b [NE];
  int  n         = -1;
  int  reset_at  = -1;
  int  last_edge = -100;
  int  beats     = 0;
  bit  in_stream = 1'b0;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  function automatic logic [W*H-1:0] rnd_a();
    logic [W*H-1:0] r;
    for (int i = 0; i < H; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  function automatic logic [W*V-1:0] rnd_b();
    logic [W*V-1:0] r;
    for (int i = 0; i < V; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  // One clock cycle: drive, check ready, advance model, check outputs
  task automatic step(input bit rst, input bit valid, input bit last,
                      input logic [W*H-1:0] a, input logic [W*V-1:0] b);
    bit flushing;
    bit rdy;
    bit acc;
    logic [W*H-1:0] ea;
    logic [W*V-1:0] eb;
    RST = rst; IN_VALID = valid; IN_LAST = last; A_IN = a; B_IN = b;
    flushing = (n >= last_edge) && (n <= last_edge + DRAIN - 1);
    rdy = !rst && !flushing;
    #1;
    check("in_ready", VW'(IN_READY), VW'(rdy));
    @(posedge CLK);
    n++;
    acc = valid && rdy;
    if (rst) begin
      in_stream = 1'b0;
      last_edge = -100;
      beats     = 0;
      reset_at  = n;
      fed_a[n]  = '0;
      fed_b[n]  = '0;
    end else begin
      fed_a[n] = acc ? a : '0;
      fed_b[n] = acc ? b : '0;
      if (acc) begin
        beats = in_stream ? ((beats < MAXB) ? beats + 1 : MAXB) : 1;
        if (last) begin
          in_stream = 1'b0;
          last_edge = n;
        end else begin
          in_stream = 1'b1;
        end
      end
    end
    @(negedge CLK);
    // Lane i now shows the word fed i edges ago, unless a reset intervened
    for (int i = 0; i < H; i++) begin
      ea[i*W +: W] = (n - i > reset_at) ? fed_a[n-i][i*W +: W] : '0;
    end
    for (int i = 0; i < V; i++) begin
      eb[i*W +: W] = (n - i > reset_at) ? fed_b[n-i][i*W +: W] : '0;
    end
    check("aa", VW'(AA), VW'(ea));
    check("bb", VW'(BB), VW'(eb));
    check("busy", VW'(BUSY),
          VW'(in_stream || ((n >= last_edge) && (n <= last_edge + DRAIN - 1))));
    check("done", VW'(DONE), VW'(n == last_edge + DRAIN - 1));
    check("beat_cnt", VW'(BEAT_CNT), VW'(beats));
  endtask

  // Absolute time guard against a stuck simulation
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W*H-1:0] sa;
    logic [W*V-1:0] sb;
    RST = 1'b1; IN_VALID = 1'b0; IN_LAST = 1'b0; A_IN = '0; B_IN = '0;
    @(negedge CLK);

    // Reset held with valid asserted, then release
    repeat (3) step(1'b1, 1'b1, 1'b0, rnd_a(), rnd_b());
    step(1'b0, 1'b0, 1'b0, rnd_a(), rnd_b());

    // Skew timing with recognisable lane values; single-beat burst
    for (int i = 0; i < H; i++) sa[i*W +: W] = W'(i + 1);
    for (int i = 0; i < V; i++) sb[i*W +: W] = W'(i + 5);
    step(1'b0, 1'b1, 1'b1, sa, sb);
    // Valid kept high through the flush: must all be refused
    repeat (15) step(1'b0, 1'b1, 1'b0, rnd_a(), rnd_b());
    repeat (2) step(1'b0, 1'b0, 1'b0, rnd_a(), rnd_b());

    // Four beats with a bubble between beats 2 and 3
    repeat (2) step(1'b0, 1'b1, 1'b0, rnd_a(), rnd_b());
    step(1'b0, 1'b0, 1'b1, rnd_a(), rnd_b());
    step(1'b0, 1'b1, 1'b0, rnd_a(), rnd_b());
    step(1'b0, 1'b1, 1'b1, rnd_a(), rnd_b());
    repeat (17) step(1'b0, 1'b0, 1'b0, rnd_a(), rnd_b());

    // Beat counter saturation (ten beats into a 3-bit counter)
    repeat (9) step(1'b0, 1'b1, 1'b0, rnd_a(), rnd_b());
    step(1'b0, 1'b1, 1'b1, rnd_a(), rnd_b());
    repeat (16) step(1'b0, 1'b0, 1'b0, rnd_a(), rnd_b());

    // Reset during flush cycle 5, then a normal burst
    step(1'b0, 1'b1, 1'b1, rnd_a(), rnd_b());
    repeat (4) step(1'b0, 1'b0, 1'b0, rnd_a(), rnd_b());
    step(1'b1, 1'b0, 1'b0, rnd_a(), rnd_b());
    repeat (3) step(1'b0, 1'b0, 1'b0, rnd_a(), rnd_b());
    step(1'b0, 1'b1, 1'b0, rnd_a(), rnd_b());
    step(1'b0, 1'b1, 1'b1, rnd_a(), rnd_b());
    repeat (16) step(1'b0, 1'b0, 1'b0, rnd_a(), rnd_b());

    // Random back-to-back bursts, stray IN_LAST without valid, rare resets
    repeat (220) begin
      step(($urandom % 60) == 0, ($urandom % 4) != 0, ($urandom % 4) == 0,
           rnd_a(), rnd_b());
    end
    repeat (20) step(1'b0, 1'b0, 1'b0, rnd_a(), rnd_b());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_skew_feeder.md
Name: sa_skew_feeder

Overview:
Upstream operand feeder for the r8 systolic array. Accepts one row of HPE A-operands and one column of VPE B-operands per beat over a valid/ready handshake, and applies the diagonal skew the array needs (lane i delayed i cycles). Drives the array's AA/BB buses directly. After the last beat it injects zeros long enough to drain the wavefront through the array, then signals completion.

Parameters:
WIDTH, 32, operand word width in bits
HPE, 8, horizontal PE count (A lanes)
VPE, 8, vertical PE count (B lanes)
CNTW, 16, width of beat counter

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
A_IN  input  WIDTH*HPE  A row; lane i at [(i+1)*WIDTH-1 : i*WIDTH]
B_IN  input  WIDTH*VPE  B column; same lane packing
IN_VALID  input  1  A_IN/B_IN/IN_LAST valid
IN_LAST  input  1  final beat of burst (qualified by IN_VALID)
IN_READY  output  1  feeder accepts beat this cycle
AA  output  WIDTH*HPE  skewed A to array, same packing
BB  output  WIDTH*VPE  skewed B to array, same packing
BUSY  output  1  state is STREAM or FLUSH
DONE  output  1  one-cycle pulse when flush completes
BEAT_CNT  output  CNTW  beats accepted in current/last burst

Behaviour:
- Clock CLK, synchronous active-high reset RST. While RST=1 at an edge: all skew registers, AA, BB = 0; state IDLE; BEAT_CNT=0; DONE=0; BUSY=0. IN_READY=0 while RST high.
- Accept = IN_VALID & IN_READY. IN_READY=1 in IDLE and STREAM, 0 in FLUSH.
- Skew: per-lane shift chain, lane i has depth i+1 registers (triangular). Chain shifts every cycle unconditionally. Chain input = lane word on accept, else 0 (bubble). Lane i word accepted at edge t appears on AA/BB lane i after edge t+i (lane 0 latency 1 cycle). Zero bubbles are harmless to array MAC accumulation.
- States:
  IDLE: accept & !IN_LAST -> STREAM; accept & IN_LAST -> FLUSH (single-beat burst). On accept in IDLE, BEAT_CNT <= 1.
  STREAM: each accept BEAT_CNT++ (saturates at all-ones); accept & IN_LAST -> FLUSH; no accept -> stay, bubble inserted.
  FLUSH: down-counter loaded with DRAIN = HPE+VPE-1 on entry; zeros fed; at counter==1 -> IDLE with DONE=1 for that one cycle.
- IN_LAST with IN_VALID=0 ignored.
- BEAT_CNT holds value after DONE until next burst's first accept.
- Reset mid-STREAM/FLUSH: everything cleared, no DONE pulse, IDLE next cycle.
- Back-to-back: beat accepted in IDLE the cycle after DONE is legal; new burst's data enters chains while tail zeros still shift out (no overlap of non-zero data because flush already drained).
- Asymmetric HPE≠VPE supported; skew depth per side uses its own lane count.

Decomposition:
- Shared package sa_pkg: state encoding (IDLE=0, STREAM=1, FLUSH=2), DRAIN constant function of HPE/VPE, lane-slice helper.
- One sub-module sa_skew_lane (parameters WIDTH, DEPTH): single-lane shift chain with sync reset, instantiated per A and B lane via generate. FSM and counters in top.

Test Plan:
- Reset: hold RST=1 3 cycles with IN_VALID=1 -> AA=BB=0, IN_READY=0, BUSY=0, BEAT_CNT=0; release -> IN_READY=1.
- Skew timing (HPE=VPE=4): one beat A lanes {1,2,3,4}, B {5,6,7,8}, IN_LAST=1 -> AA lane i = i+1 exactly at cycle i+1 after accept, zero otherwise; BB likewise.
- Flush/DONE: single-beat burst at cycle 0 (HPE=VPE=8) -> BUSY 1 from cycle 1, DONE pulse at cycle 15, IN_READY=0 cycles 1-15, BEAT_CNT=1.
- Bubbles: 4-beat burst with IN_VALID low between beats 2 and 3 -> zero word inserted on every lane at that slot, BEAT_CNT=4, DONE 15 cycles after last accept.
- Reset mid-FLUSH: RST high at flush cycle 5 -> no DONE, all outputs 0 next cycle, accepts next burst normally.
- Back-to-back bursts: new accept cycle after DONE -> BEAT_CNT restarts at 1, no corruption of AA/BB ordering.
